// File: rtl/hazard_fwd_ctrl.sv
// Hazard, forwarding and flush control for an N-deep in-order RISC-V pipe.
// Tracks downstream destination registers in a shift-register scoreboard.
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int DEPTH        = 2,
  parameter int LOAD_STAGE   = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int FW           = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_valid,
  input  logic                  id_rs2_valid,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_wr,
  input  logic                  id_is_load,
  input  logic                  br_taken,
  output logic [FW-1:0]         fwd_a,
  output logic [FW-1:0]         fwd_b,
  output logic                  stall,
  output logic                  flush,
  output logic [DEPTH-1:0]      stage_valid
);

  localparam int CW = 3;

  logic [DEPTH-1:0]                 vld_q, vld_d;
  logic [DEPTH-1:0]                 wr_q, wr_d;
  logic [DEPTH-1:0]                 ld_q, ld_d;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q, rd_d;
  logic [CW-1:0]                    cnt_q, cnt_d;

  logic use_a, use_b;
  logic hz_a, hz_b;
  logic br_ok;
  logic bubble;

  assign use_a = id_valid & id_rs1_valid & (id_rs1 != '0);
  assign use_b = id_valid & id_rs2_valid & (id_rs2 != '0);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
    hz_a  = 1'b0;
    hz_b  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (use_a && vld_q[k] && wr_q[k] && rd_q[k] == id_rs1) begin
        fwd_a = FW'(k + 1);
        hz_a  = ld_q[k] && (k + 1 < LOAD_STAGE);
      end
      if (use_b && vld_q[k] && wr_q[k] && rd_q[k] == id_rs2) begin
        fwd_b = FW'(k + 1);
        hz_b  = ld_q[k] && (k + 1 < LOAD_STAGE);
      end
    end
  end

  assign br_ok       = br_taken & vld_q[0];
  assign flush       = br_ok | (cnt_q != '0);
  assign stall       = ~flush & (hz_a | hz_b);
  assign bubble      = flush | stall | ~id_valid;
  assign stage_valid = vld_q;

  always_comb begin
    vld_d = vld_q;
    wr_d  = wr_q;
    ld_d  = ld_q;
    rd_d  = rd_q;
    for (int k = DEPTH - 1; k >= 1; k--) begin
      vld_d[k] = vld_q[k-1];
      wr_d[k]  = wr_q[k-1];
      ld_d[k]  = ld_q[k-1];
      rd_d[k]  = rd_q[k-1];
    end
    if (bubble) begin
      vld_d[0] = 1'b0;
      wr_d[0]  = 1'b0;
      ld_d[0]  = 1'b0;
      rd_d[0]  = '0;
    end else begin
      vld_d[0] = 1'b1;
      wr_d[0]  = id_reg_wr & (id_rd != '0);
      ld_d[0]  = id_is_load;
      rd_d[0]  = id_rd;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (br_ok)
      cnt_d = CW'(FLUSH_CYCLES - 1);
    else if (cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      wr_q  <= '0;
      ld_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      wr_q  <= wr_d;
      ld_q  <= ld_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl (DEPTH=2, LOAD_STAGE=2, FLUSH_CYCLES=3).
// Stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_hazard_fwd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_rs1_valid = 1'b0;
  logic       id_rs2_valid = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_reg_wr = 1'b0;
  logic       id_is_load = 1'b0;
  logic       br_taken = 1'b0;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, flush;
  logic [1:0] stage_valid;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(
    .REG_ADDR_W  (5),
    .DEPTH       (2),
    .LOAD_STAGE  (2),
    .FLUSH_CYCLES(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_valid(id_rs1_valid),
    .id_rs2_valid(id_rs2_valid),
    .id_rd       (id_rd),
    .id_reg_wr   (id_reg_wr),
    .id_is_load  (id_is_load),
    .br_taken    (br_taken),
    .fwd_a       (fwd_a),
    .fwd_b       (fwd_b),
    .stall       (stall),
    .flush       (flush),
    .stage_valid (stage_valid)
  );

  typedef struct {
    string      nm;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
    logic       fl;
    logic [1:0] sv;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input string f,
                     input logic [3:0] act, input logic [3:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s.%s got=%0h want=%0h", nm, f, act, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.nm, "fwd_a", {2'b0, fwd_a}, {2'b0, e.fa});
        chk(e.nm, "fwd_b", {2'b0, fwd_b}, {2'b0, e.fb});
        chk(e.nm, "stall", {3'b0, stall}, {3'b0, e.st});
        chk(e.nm, "flush", {3'b0, flush}, {3'b0, e.fl});
        chk(e.nm, "stage_valid", {2'b0, stage_valid}, {2'b0, e.sv});
      end
    end
  end

  task automatic step(
    input string nm, input logic r, input logic v,
    input logic [4:0] a, input logic av,
    input logic [4:0] b, input logic bv,
    input logic [4:0] d, input logic w, input logic l, input logic br,
    input logic [1:0] efa, input logic [1:0] efb,
    input logic est, input logic efl, input logic [1:0] esv);
    exp_t e;
    @(posedge clk);
    #1;
    rst          = r;
    id_valid     = v;
    id_rs1       = a;
    id_rs1_valid = av;
    id_rs2       = b;
    id_rs2_valid = bv;
    id_rd        = d;
    id_reg_wr    = w;
    id_is_load   = l;
    br_taken     = br;
    e.nm = nm;
    e.fa = efa;
    e.fb = efb;
    e.st = est;
    e.fl = efl;
    e.sv = esv;
    q.push_back(e);
  endtask

  initial begin
    //    name     r  v  rs1 v  rs2 v  rd  w  l  br   fa fb st fl sv
    step("rst0",   0, 1, 5, 1, 5, 1, 5, 1, 1, 1,   0, 0, 0, 0, 2'b00);
    step("nop",    1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00);
    step("addi5",  1, 1, 0, 1, 0, 0, 5, 1, 0, 0,   0, 0, 0, 0, 2'b00);
    step("b2b",    1, 1, 5, 1, 5, 1, 6, 1, 0, 0,   1, 1, 0, 0, 2'b01);
    step("gap",    1, 1, 5, 1, 6, 1, 7, 1, 0, 0,   2, 1, 0, 0, 2'b11);
    step("wr5a",   1, 1, 0, 1, 0, 0, 5, 1, 0, 0,   0, 0, 0, 0, 2'b11);
    step("wr5b",   1, 1, 5, 1, 0, 0, 5, 1, 0, 0,   1, 0, 0, 0, 2'b11);
    step("young",  1, 1, 5, 1, 0, 1, 9, 1, 0, 0,   1, 0, 0, 0, 2'b11);
    step("addx0",  1, 1, 0, 1, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 2'b11);
    step("rdx0",   1, 1, 0, 1, 0, 1, 10, 1, 0, 0,  0, 0, 0, 0, 2'b11);
    step("lw7",    1, 1, 0, 1, 0, 0, 7, 1, 1, 0,   0, 0, 0, 0, 2'b11);
    step("luse",   1, 1, 7, 1, 0, 1, 8, 1, 0, 0,   1, 0, 1, 0, 2'b11);
    step("luse2",  1, 1, 7, 1, 0, 1, 8, 1, 0, 1,   2, 0, 0, 0, 2'b10);
    step("nop2",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b01);
    step("lw7b",   1, 1, 0, 1, 0, 0, 7, 1, 1, 0,   0, 0, 0, 0, 2'b10);
    step("br",     1, 1, 7, 1, 0, 1, 8, 1, 0, 1,   1, 0, 0, 1, 2'b01);
    step("fl2",    1, 1, 7, 1, 0, 1, 8, 1, 0, 0,   2, 0, 0, 1, 2'b10);
    step("fl3",    1, 1, 7, 1, 0, 1, 8, 1, 0, 0,   0, 0, 0, 1, 2'b00);
    step("flend",  1, 1, 7, 1, 0, 1, 8, 1, 0, 0,   0, 0, 0, 0, 2'b00);
    step("wr3",    1, 1, 0, 0, 0, 0, 3, 1, 0, 0,   0, 0, 0, 0, 2'b01);
    step("br2",    1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 1, 2'b11);
    step("rstfl",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00);
    step("post",   1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00);
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain left=%0d want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
Name: hazard_fwd_ctrl

Overview:
- Parametrised successor of the 3-stage forwarding/flush logic: a hazard, forwarding and flush controller for an N-deep in-order RISC-V pipeline.
- Holds a scoreboard shift register of destination-register info for DEPTH downstream stages.
- Selects the forwarding source per operand, detects load-use hazards (stall plus bubble) and sequences multi-cycle branch flushes.
- Sits between the decode-stage control decoder and the datapath operand muxes.

Parameters:
- REG_ADDR_W, 5: register-index width.
- DEPTH, 2: downstream stages tracked (1..4). Stage 1 is the stage immediately after decode.
- LOAD_STAGE, 2: first stage index (1..DEPTH) whose load data is forwardable.
- FLUSH_CYCLES, 1: cycles flush stays asserted after a taken branch (1..7).
- FW, $clog2(DEPTH+1): forwarding-select width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode-stage instruction valid.
- id_rs1  in  REG_ADDR_W  decode source 1 index.
- id_rs2  in  REG_ADDR_W  decode source 2 index.
- id_rs1_valid  in  1  instruction reads rs1.
- id_rs2_valid  in  1  instruction reads rs2.
- id_rd  in  REG_ADDR_W  decode destination index.
- id_reg_wr  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- br_taken  in  1  branch/jump in stage 1 resolved taken.
- fwd_a  out  FW  rs1 source: 0 = register file, k = stage k result.
- fwd_b  out  FW  rs2 source, same encoding.
- stall  out  1  hold PC and decode register this cycle.
- flush  out  1  kill decode-stage (and fetch) instruction this cycle.
- stage_valid  out  DEPTH  scoreboard valid bits (bit k-1 = stage k).

Behaviour:
- Reset (rst=0, asynchronous):
  - All scoreboard entries cleared (valid=0, reg_wr=0, is_load=0, rd=0); flush counter cleared to 0.
  - While rst=0: stall=0, flush=0, fwd_a=0, fwd_b=0, stage_valid=0.
  - Reset asserted mid-flush or mid-stall abandons that operation immediately.
- Scoreboard update, every posedge clk:
  - entry[k+1] <= entry[k] for k = 1..DEPTH-1; entry[DEPTH] is dropped.
  - entry[1] <= bubble (all zero) if flush or stall or !id_valid; otherwise {1, id_rd, id_reg_wr & (id_rd != 0), id_is_load}.
- Forwarding (combinational, per operand):
  - Search k = 1..DEPTH in order and take the first entry with valid & reg_wr & rd == rs. The youngest match wins.
  - fwd = k; if no match, fwd = 0.
  - fwd = 0 whenever the operand's *_valid = 0, rs = 0, or id_valid = 0.
- Load-use hazard (combinational):
  - stall = 1 when either operand's selected match k has is_load = 1 and k < LOAD_STAGE.
  - While stall = 1, fwd_a and fwd_b still show the match (consumers must ignore them).
  - Stall persists until the load reaches LOAD_STAGE, i.e. LOAD_STAGE - k cycles.
- Flush:
  - br_taken is qualified by stage_valid[0]; unqualified br_taken is ignored.
  - A qualified br_taken drives flush = 1 in the same cycle and loads the counter with FLUSH_CYCLES - 1.
  - flush = 1 while the counter is nonzero; the counter decrements each cycle.
  - A new qualified br_taken while the counter is nonzero reloads the counter.
  - flush has priority over stall: when flush = 1, stall = 0.
- Boundaries:
  - DEPTH = 1: only stage 1 is searched.
  - LOAD_STAGE = 1: loads never stall.
  - rd = 0 never creates a match.
  - Simultaneous stall and flush: flush wins, bubble inserted.
- Latency:
  - fwd, stall and flush are combinational from the inputs and current scoreboard state.
  - Scoreboard and counter updates take one cycle.

Test Plan:
- Reset: DEPTH=2, rst low then high with id_valid=0 -> stall_valid… stage_valid=00, stall=0, flush=0, fwd_a=fwd_b=0.
- Back-to-back forwarding: addi x5 then add x6,x5,x5 -> fwd_a=fwd_b=1. With one independent instruction between -> fwd=2.
- Youngest wins: x5 written in stage 1 and stage 2 -> fwd_a=1.
- Load-use, LOAD_STAGE=2: lw x7, then add x8,x7,x0 next cycle -> stall=1 for exactly 1 cycle, stage_valid=01 then 10, then fwd_a=2, stall=0.
- x0 hazard: addi x0 followed by a reader of x0 -> fwd=0, stall=0.
- Flush, FLUSH_CYCLES=3: taken branch in stage 1 -> flush=1 for 3 cycles, stage_valid bit 0 = 0 on the following 3 edges. A simultaneous load-use condition -> stall=0.
